// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl: routes data_io download bytes through a 4-entry FIFO to
// SDRAM port 1 (CPU ROM), SDRAM port 2 (graphics ROM) or the palette RAM, and
// tracks download completion to drive the stretched core reset.
module rom_download_ctrl #(
   parameter logic [24:0] CPU_BASE   = 25'h10000,
   parameter logic [24:0] PAL_BASE   = 25'h20000,
   parameter int unsigned RESET_HOLD = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        reset_req,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic        pal_wr,
   output logic [4:0]  pal_addr,
   output logic [7:0]  pal_data,
   output logic        rom_loaded,
   output logic        core_reset,
   output logic        overflow,
   output logic        busy
);

   localparam int unsigned CW = $clog2(RESET_HOLD + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT1, S_WAIT2} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_wr_last;
   logic [32:0] r_fifo [4];
   logic [1:0]  r_wptr, r_rptr;
   logic [2:0]  r_count;
   logic        r_overflow;

   logic        r_p1_req, r_p2_req;
   logic [22:0] r_p1_a, r_p2_a;
   logic [1:0]  r_p1_ds, r_p2_ds;
   logic [15:0] r_p1_d, r_p2_d;
   logic        r_pal_wr;
   logic [4:0]  r_pal_addr;
   logic [7:0]  r_pal_data;

   logic        r_dl_last, r_dl_seen, r_loaded;
   logic [CW-1:0] r_hold;

   logic        w_push_req, w_push, w_pop, w_full, w_empty;
   logic [32:0] w_push_data, w_head;
   logic [24:0] w_addr, w_cpu_off, w_pal_off;
   logic [7:0]  w_data;
   logic        w_is_gfx, w_is_cpu, w_is_pal;
   logic        w_issue1, w_issue2, w_pal_wr;
   logic        w_raw_reset;

   assign w_push_req  = ioctl_download & ioctl_wr & ~r_wr_last;
   assign w_push_data = {ioctl_addr, ioctl_dout};
   assign w_full      = (r_count == 3'd4);
   assign w_empty     = (r_count == 3'd0);
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign w_push      = w_push_req & (~w_full | w_pop);

   assign w_head    = r_fifo[r_rptr];
   assign w_addr    = w_head[32:8];
   assign w_data    = w_head[7:0];
   assign w_cpu_off = w_addr - CPU_BASE;
   assign w_pal_off = w_addr - PAL_BASE;
   assign w_is_gfx  = (w_addr < 25'h10000);
   assign w_is_cpu  = (w_addr >= CPU_BASE) && (w_cpu_off < 25'h10000);
   assign w_is_pal  = (w_addr >= PAL_BASE) && (w_pal_off < 25'd32);

   // Rising-edge detector on the byte strobe
   always_ff @(posedge clk_sys) begin
      if (reset) r_wr_last <= 1'b0;
      else       r_wr_last <= ioctl_wr;
   end

   // FIFO storage; contents are only meaningful while the count covers them
   always_ff @(posedge clk_sys) begin
      if (w_push) r_fifo[r_wptr] <= w_push_data;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 2'd1;
         if (w_pop)  r_rptr <= r_rptr + 2'd1;
         if (w_push && !w_pop)      r_count <= r_count + 3'd1;
         else if (!w_push && w_pop) r_count <= r_count - 3'd1;
         if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // Issue state register
   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Head decode, issue decisions and pop timing
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_issue1    = 1'b0;
      w_issue2    = 1'b0;
      w_pal_wr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (w_is_gfx) begin
                  w_issue2    = 1'b1;
                  w_state_nxt = S_WAIT2;
               end else if (w_is_cpu) begin
                  w_issue1    = 1'b1;
                  w_state_nxt = S_WAIT1;
               end else if (w_is_pal) begin
                  w_pal_wr = 1'b1;
                  w_pop    = 1'b1;
               end else begin
                  w_pop = 1'b1;
               end
            end
         end
         S_WAIT1: begin
            if (port1_ack == r_p1_req) begin
               w_pop       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT2: begin
            if (port2_ack == r_p2_req) begin
               w_pop       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // SDRAM request registers and palette write port; values hold until the next issue
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_p1_req   <= 1'b0;
         r_p1_a     <= '0;
         r_p1_ds    <= '0;
         r_p1_d     <= '0;
         r_p2_req   <= 1'b0;
         r_p2_a     <= '0;
         r_p2_ds    <= '0;
         r_p2_d     <= '0;
         r_pal_wr   <= 1'b0;
         r_pal_addr <= '0;
         r_pal_data <= '0;
      end else begin
         r_pal_wr <= w_pal_wr;
         if (w_pal_wr) begin
            r_pal_addr <= w_addr[4:0];
            r_pal_data <= w_data;
         end
         if (w_issue1) begin
            r_p1_req <= ~r_p1_req;
            r_p1_a   <= w_cpu_off[23:1];
            r_p1_ds  <= {w_cpu_off[0], ~w_cpu_off[0]};
            r_p1_d   <= {w_data, w_data};
         end
         if (w_issue2) begin
            // A13 becomes the byte select, so it is squeezed out of the word address.
            r_p2_req <= ~r_p2_req;
            r_p2_a   <= {w_addr[23:15], w_addr[14], w_addr[12:0]};
            r_p2_ds  <= {w_addr[13], ~w_addr[13]};
            r_p2_d   <= {w_data, w_data};
         end
      end
   end

   // Download completion tracking
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_dl_last <= 1'b0;
         r_dl_seen <= 1'b0;
         r_loaded  <= 1'b0;
      end else begin
         r_dl_last <= ioctl_download;
         if (ioctl_download) r_dl_seen <= 1'b1;
         if (ioctl_download && !r_dl_last)
            r_loaded <= 1'b0;
         else if (!ioctl_download && w_empty && (r_state == S_IDLE) && r_dl_seen)
            r_loaded <= 1'b1;
      end
   end

   assign w_raw_reset = reset | reset_req | ~r_loaded | ioctl_download;

   // Core reset stretch counter, reloaded while any reset source is active
   always_ff @(posedge clk_sys) begin
      if (reset)                r_hold <= CW'(RESET_HOLD);
      else if (w_raw_reset)     r_hold <= CW'(RESET_HOLD);
      else if (r_hold != '0)    r_hold <= r_hold - CW'(1);
   end

   assign port1_req  = r_p1_req;
   assign port1_a    = r_p1_a;
   assign port1_ds   = r_p1_ds;
   assign port1_d    = r_p1_d;
   assign port2_req  = r_p2_req;
   assign port2_a    = r_p2_a;
   assign port2_ds   = r_p2_ds;
   assign port2_d    = r_p2_d;
   assign pal_wr     = r_pal_wr;
   assign pal_addr   = r_pal_addr;
   assign pal_data   = r_pal_data;
   assign rom_loaded = r_loaded;
   assign core_reset = w_raw_reset | (r_hold != '0);
   assign overflow   = r_overflow;
   assign busy       = ~w_empty | (r_state != S_IDLE);

endmodule
